// File: rtl/stack_unit.sv
// stack_unit: hardware stack with registered TOS, live count and sticky overflow/underflow errors
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear_err,
    output logic [DATA_W-1:0] tos,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              err_halt
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;
    logic [DATA_W-1:0] mem_q [0:DEPTH-2];
    logic [DATA_W-1:0] tos_q, tos_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic              is_empty, is_full, do_push, do_pop, do_repl, ovf_evt, unf_evt, mem_we;
    logic [AW-1:0]     rd_idx, wr_idx;
    always_comb begin
        is_empty    = count_q == '0;
        is_full     = count_q == CNT_W'(DEPTH);
        do_push     = push && (!pop || is_empty) && !is_full;
        do_pop      = pop && !push && !is_empty;
        do_repl     = push && pop && !is_empty;
        ovf_evt     = push && !pop && is_full;
        unf_evt     = pop && !push && is_empty;
        rd_idx      = AW'(count_q - CNT_W'(2));
        wr_idx      = AW'(count_q - CNT_W'(1));
        mem_we      = do_push && !is_empty;
        tos_d       = (do_push || do_repl) ? data_in
                    : do_pop ? ((count_q >= CNT_W'(2)) ? mem_q[rd_idx] : '0)
                    : tos_q;
        count_d     = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        overflow_d  = ovf_evt || (overflow_q && !clear_err);
        underflow_d = unf_evt || (underflow_q && !clear_err);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem_q[wr_idx] <= tos_q;
    end
    assign tos       = tos_q;
    assign count     = count_q;
    assign empty     = count_q == '0;
    assign full      = count_q == CNT_W'(DEPTH);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign err_halt  = overflow_q | underflow_q;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed scoreboard bench for stack_unit
module tb_stack_unit;
    logic       clk = 1'b0;
    logic       rst, push, pop, clear_err;
    logic [7:0] data_in, tos;
    logic [3:0] count;
    logic       empty, full, overflow, underflow, err_halt;
    typedef struct packed {
        logic [7:0] tos;
        logic [3:0] cnt;
        logic       e, f, o, u, h;
    } obs_t;
    obs_t  exp_q [$];
    string name_q [$];
    int    checks = 0;
    int    errors = 0;
    stack_unit #(.DATA_W(8), .DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in),
        .clear_err(clear_err), .tos(tos), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow), .err_halt(err_halt)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin : monitor
        obs_t  e, a;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{tos, count, empty, full, overflow, underflow, err_halt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got tos=%h cnt=%0d e=%b f=%b o=%b u=%b h=%b, expected tos=%h cnt=%0d e=%b f=%b o=%b u=%b h=%b",
                         n, a.tos, a.cnt, a.e, a.f, a.o, a.u, a.h, e.tos, e.cnt, e.e, e.f, e.o, e.u, e.h);
            end
        end
    end
    task automatic op(input logic r, input logic p, input logic q, input logic [7:0] d, input logic c,
                      input logic [7:0] et, input logic [3:0] ec, input logic eo, input logic eu,
                      input string nm);
        @(negedge clk);
        rst = r; push = p; pop = q; data_in = d; clear_err = c;
        @(posedge clk);
        #1;
        exp_q.push_back('{et, ec, ec == 4'd0, ec == 4'd8, eo, eu, eo | eu});
        name_q.push_back(nm);
        rst = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00; clear_err = 1'b0;
    endtask
    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = 8'h00; clear_err = 1'b0;
        op(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "reset");
        op(0, 1, 0, 8'h11, 0, 8'h11, 1, 0, 0, "push11");
        op(0, 1, 0, 8'h22, 0, 8'h22, 2, 0, 0, "push22");
        op(0, 1, 0, 8'h33, 0, 8'h33, 3, 0, 0, "push33");
        op(0, 0, 0, 8'hEE, 0, 8'h33, 3, 0, 0, "hold");
        op(0, 0, 1, 8'h00, 0, 8'h22, 2, 0, 0, "pop1");
        op(0, 0, 1, 8'h00, 0, 8'h11, 1, 0, 0, "pop2");
        op(0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0, "pop3");
        for (int i = 1; i <= 8; i++) op(0, 1, 0, 8'(i), 0, 8'(i), 4'(i), 0, 0, "fill");
        op(0, 1, 0, 8'h99, 0, 8'h08, 8, 1, 0, "overflow");
        op(0, 0, 1, 8'h00, 0, 8'h07, 7, 1, 0, "pop_after_ovf");
        op(0, 0, 0, 8'h00, 1, 8'h07, 7, 0, 0, "clear_ovf");
        op(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "reset2");
        op(0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 1, "underflow");
        op(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, "unf_sticky");
        op(0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, "clear_unf");
        op(0, 1, 0, 8'h05, 0, 8'h05, 1, 0, 0, "push05");
        op(0, 1, 1, 8'h0A, 0, 8'h0A, 1, 0, 0, "replace");
        op(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "reset3");
        for (int i = 1; i <= 8; i++) op(0, 1, 0, 8'(i), 0, 8'(i), 4'(i), 0, 0, "fill2");
        op(0, 1, 1, 8'h0B, 0, 8'h0B, 8, 0, 0, "replace_full");
        op(0, 0, 1, 8'h00, 0, 8'h07, 7, 0, 0, "pop_after_repl");
        op(0, 0, 1, 8'h00, 0, 8'h06, 6, 0, 0, "pop_deep");
        op(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "reset4");
        op(0, 1, 1, 8'h44, 0, 8'h44, 1, 0, 0, "repl_empty");
        op(0, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0, "pop44");
        op(0, 0, 1, 8'h00, 1, 8'h00, 0, 0, 1, "unf_with_clear");
        op(0, 1, 0, 8'h01, 0, 8'h01, 1, 0, 1, "push_unf_kept");
        op(0, 1, 0, 8'h02, 0, 8'h02, 2, 0, 1, "push2");
        op(0, 1, 0, 8'h03, 1, 8'h03, 3, 0, 0, "push3_clear");
        op(1, 1, 0, 8'h55, 0, 8'h00, 0, 0, 0, "reset_with_push");
        op(0, 1, 0, 8'h66, 0, 8'h66, 1, 0, 0, "push_after_reset");
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
